// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register offsets and bit positions for the mmio responder
package mmio_pkg;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_TXDATA  = 3'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTOCLR = 1;
    localparam int CTRL_IE      = 2;

    localparam int ST_MATCH    = 0;
    localparam int ST_OVF      = 1;
    localparam int ST_FULL     = 2;
    localparam int ST_EMPTY    = 3;
    localparam int ST_LEVEL_LO = 4;
    localparam int ST_LEVEL_HI = 7;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with head output and occupancy level
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full  = (r_level == LVL_FULL);
    assign empty = (r_level == '0);
    assign level = r_level;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - data-bus peripheral with compare timer and transmit FIFO
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        irq,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]    r_ctrl;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_match;
    logic          r_ovf;

    logic [2:0]    w_off;
    logic          w_wr;
    logic          w_wr_ctrl, w_wr_count, w_wr_compare, w_wr_status, w_wr_txdata;
    logic          w_en;
    logic          w_match_set;
    logic          w_ovf_set;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [LW-1:0] w_level;
    logic [31:0]   w_status;
    logic          w_unused_byte_lane;

    assign w_off              = a[4:2];
    assign w_unused_byte_lane = ^a[1:0];
    assign hit                = (a[31:5] == BASE_ADDR[31:5]);
    assign w_wr               = we & hit;
    assign w_wr_ctrl          = w_wr & (w_off == OFF_CTRL);
    assign w_wr_count         = w_wr & (w_off == OFF_COUNT);
    assign w_wr_compare       = w_wr & (w_off == OFF_COMPARE);
    assign w_wr_status        = w_wr & (w_off == OFF_STATUS);
    assign w_wr_txdata        = w_wr & (w_off == OFF_TXDATA);

    assign w_en        = r_ctrl[CTRL_EN];
    // A software load of COUNT pre-empts the compare for that cycle.
    assign w_match_set = w_en & (r_count == r_compare) & ~w_wr_count;
    assign tx_valid    = ~w_empty;
    assign w_pop       = tx_valid & tx_ready;
    assign w_ovf_set   = w_wr_txdata & w_full & ~w_pop;
    assign irq         = r_match & r_ctrl[CTRL_IE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl    <= '0;
            r_count   <= '0;
            r_compare <= '1;
            r_match   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr_ctrl)    r_ctrl    <= wd[2:0];
            if (w_wr_compare) r_compare <= wd;
            if (w_wr_count)
                r_count <= wd;
            else if (w_en)
                r_count <= (w_match_set && r_ctrl[CTRL_AUTOCLR]) ? '0 : r_count + 32'd1;
            // Hardware set wins over a write-one-to-clear in the same cycle.
            if (w_match_set)                       r_match <= 1'b1;
            else if (w_wr_status && wd[ST_MATCH])  r_match <= 1'b0;
            if (w_ovf_set)                         r_ovf   <= 1'b1;
            else if (w_wr_status && wd[ST_OVF])    r_ovf   <= 1'b0;
        end
    end

    always_comb begin
        w_status                          = '0;
        w_status[ST_MATCH]                = r_match;
        w_status[ST_OVF]                  = r_ovf;
        w_status[ST_FULL]                 = w_full;
        w_status[ST_EMPTY]                = w_empty;
        w_status[ST_LEVEL_HI:ST_LEVEL_LO] = 4'(w_level);
    end

    always_comb begin
        rd = '0;
        if (hit) begin
            case (w_off)
                OFF_CTRL:    rd = {29'h0, r_ctrl};
                OFF_COUNT:   rd = r_count;
                OFF_COMPARE: rd = r_compare;
                OFF_STATUS:  rd = w_status;
                default:     rd = '0;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_wr_txdata),
        .pop   (w_pop),
        .din   (wd),
        .dout  (tx_data),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - randomized and directed checks against a register-map model
module tb_mmio_responder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] wd = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] rd;
    logic        hit;
    logic        irq;
    logic [31:0] tx_data;
    logic        tx_valid;

    mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .hit      (hit),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    logic [2:0]  m_ctrl;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_match;
    logic        m_ovf;
    logic [31:0] m_q[$];

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_ctrl    = '0;
        m_count   = '0;
        m_compare = 32'hFFFF_FFFF;
        m_match   = 1'b0;
        m_ovf     = 1'b0;
        m_q.delete();
    endtask

    function automatic logic m_hit(input logic [31:0] ad);
        return ad[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] ad);
        if (!m_hit(ad)) return 32'h0;
        case (ad[4:2])
            3'd0: return {29'h0, m_ctrl};
            3'd1: return m_count;
            3'd2: return m_compare;
            3'd3: return {24'h0, 4'(m_q.size()), 1'(m_q.size() == 0),
                          1'(m_q.size() == DEPTH), m_ovf, m_match};
            default: return 32'h0;
        endcase
    endfunction

    // Next-state of the whole peripheral for one clock edge, from the register-map rules.
    task automatic m_step(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic rdy);
        bit       wr, pop, full, push, mset;
        bit [2:0] off;
        wr   = w && m_hit(ad);
        off  = ad[4:2];
        pop  = (m_q.size() != 0) && rdy;
        full = (m_q.size() == DEPTH);
        push = wr && (off == 3'd4);
        mset = 1'b0;
        if (wr && off == 3'd1) m_count = d;
        else if (m_ctrl[0]) begin
            if (m_count == m_compare) begin
                mset    = 1'b1;
                m_count = m_ctrl[1] ? 32'h0 : m_count + 32'd1;
            end else begin
                m_count = m_count + 32'd1;
            end
        end
        if (mset) m_match = 1'b1;
        else if (wr && off == 3'd3 && d[0]) m_match = 1'b0;
        if (push && full && !pop) m_ovf = 1'b1;
        else if (wr && off == 3'd3 && d[1]) m_ovf = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (push && !(full && !pop)) m_q.push_back(d);
        if (wr && off == 3'd0) m_ctrl = d[2:0];
        if (wr && off == 3'd2) m_compare = d;
    endtask

    // One bus cycle: drive, check outputs against the model, then take the edge.
    task automatic cyc(input logic w, input logic [31:0] ad, input logic [31:0] d,
                       input logic rdy, input bit rd_chk);
        we = w; a = ad; wd = d; tx_ready = rdy;
        #1;
        chk("hit", hit, m_hit(ad));
        chk("tx_valid", tx_valid, m_q.size() != 0);
        chk("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
        chk("irq", irq, m_match & m_ctrl[2]);
        if (rd_chk) chk($sformatf("rd@%h", ad), rd, m_read(ad));
        m_step(w, ad, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [31:0] ad, input logic [31:0] mask,
                        input logic [31:0] exp);
        we = 1'b0; a = ad;
        #1;
        chk(tag, rd & mask, exp);
    endtask

    logic [31:0] cnt_seq [8] = '{0, 1, 2, 3, 4, 5, 0, 1};
    logic [31:0] drain   [4] = '{32'h22, 32'h33, 32'h44, 32'h66};

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        peek("rst_ctrl",    BASE + 32'h00, '1, 32'h0);
        peek("rst_count",   BASE + 32'h04, '1, 32'h0);
        peek("rst_compare", BASE + 32'h08, '1, 32'hFFFF_FFFF);
        peek("rst_status",  BASE + 32'h0C, '1, 32'h8);
        peek("rst_txdata",  BASE + 32'h10, '1, 32'h0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, BASE + 32'(i * 4), 32'h0, 1'b0, 1'b1);

        cyc(1'b1, BASE + 32'h08, 32'd5, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h00, 32'd3, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h04, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            peek($sformatf("count_seq%0d", i), BASE + 32'h04, '1, cnt_seq[i]);
            cyc(1'b0, BASE + 32'h04, 32'h0, 1'b0, 1'b1);
        end
        peek("match_set", BASE + 32'h0C, 32'h1, 32'h1);
        chk("irq_ie0", irq, 1'b0);
        cyc(1'b1, BASE + 32'h00, 32'd7, 1'b0, 1'b0);
        chk("irq_ie1", irq, 1'b1);
        cyc(1'b1, BASE + 32'h00, 32'd4, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h0C, 32'd1, 1'b0, 1'b0);
        peek("match_w1c", BASE + 32'h0C, 32'h1, 32'h0);
        chk("irq_cleared", irq, 1'b0);

        cyc(1'b1, BASE + 32'h08, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h04, 32'hFFFF_FFFE, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h00, 32'd1, 1'b0, 1'b0);
        peek("wrap_fffe", BASE + 32'h04, '1, 32'hFFFF_FFFE);
        cyc(1'b0, BASE + 32'h04, 32'h0, 1'b0, 1'b1);
        peek("wrap_ffff", BASE + 32'h04, '1, 32'hFFFF_FFFF);
        cyc(1'b0, BASE + 32'h04, 32'h0, 1'b0, 1'b1);
        peek("wrap_zero", BASE + 32'h04, '1, 32'h0);
        peek("wrap_nomatch", BASE + 32'h0C, 32'h1, 32'h0);
        cyc(1'b1, BASE + 32'h0C, 32'd1, 1'b0, 1'b0);
        peek("set_beats_clr", BASE + 32'h0C, 32'h1, 32'h1);
        cyc(1'b1, BASE + 32'h00, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, BASE + 32'h0C, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) cyc(1'b1, BASE + 32'h10, 32'h11 * 32'(i + 1), 1'b0, 1'b0);
        peek("fifo_full", BASE + 32'h0C, 32'hFE, 32'h46);
        chk("fifo_head", tx_data, 32'h11);
        cyc(1'b1, BASE + 32'h10, 32'h66, 1'b1, 1'b0);
        peek("push_pop_full", BASE + 32'h0C, 32'hFE, 32'h46);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d", i), tx_data, drain[i]);
            cyc(1'b0, BASE + 32'h0C, 32'h0, 1'b1, 1'b1);
        end
        peek("drain_empty", BASE + 32'h0C, 32'hFC, 32'h08);
        cyc(1'b1, BASE + 32'h0C, 32'd2, 1'b0, 1'b0);

        cyc(1'b1, 32'h0000_0064, 32'd7, 1'b0, 1'b1);
        peek("miss_no_write", BASE + 32'h00, '1, 32'h0);
        peek("hole_read", BASE + 32'h14, '1, 32'h0);
        chk("hole_hit", hit, 1'b1);
        a = 32'h0000_0064;
        #1;
        chk("miss_hit", hit, 1'b0);
        chk("miss_rd", rd, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ad, d;
            logic [2:0]  off;
            off = 3'($urandom_range(0, 7));
            ad  = ($urandom_range(0, 9) == 0) ? $urandom : BASE + {27'h0, off, 2'($urandom)};
            case (ad[4:2])
                3'd0:       d = $urandom_range(0, 7);
                3'd1, 3'd2: d = $urandom_range(0, 12);
                default:    d = $urandom;
            endcase
            cyc(1'($urandom), ad, d, 1'($urandom), 1'b1);
        end

        cyc(1'b1, BASE + 32'h00, 32'd0, 1'b0, 1'b0);
        while (m_q.size() != 0) cyc(1'b0, BASE + 32'h0C, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, BASE + 32'h10, 32'hA0 + 32'(i), 1'b0, 1'b0);
        cyc(1'b0, BASE + 32'h0C, 32'h0, 1'b1, 1'b1);
        we = 1'b0; a = BASE + 32'h0C; tx_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", tx_valid, 1'b0);
        chk("rst_mid_status", rd, 32'h8);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, BASE + 32'(i * 4), 32'h0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-mapped peripheral that answers the processor's data-memory bus (MemWrite, DataAdr, WriteData, ReadData) alongside dmem. It decodes a 32-byte window at BASE_ADDR and provides a programmable timer with compare/interrupt and a transmit FIFO drained through a valid/ready stream port. Reads are combinational so a load completes in one processor cycle, and writes commit on the rising clock edge. The top level selects ReadData from this block when `hit` is high and from dmem otherwise.

## Interface
- BASE_ADDR, 32'h0000_0100: window base; must be 32-byte aligned.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, at least 2.
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- we  input  1  store strobe (processor MemWrite).
- a  input  32  byte address (processor DataAdr).
- wd  input  32  store data (processor WriteData).
- rd  output  32  load data; combinational from `a`.
- hit  output  1  high when a[31:5] == BASE_ADDR[31:5].
- irq  output  1  high when MATCH sticky is set and CTRL.IE = 1.
- tx_data  output  32  FIFO head word.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts the head word.

## Operation
- Offset is a[4:2]; a[1:0] is ignored.
- Register map:
  - 0x00 CTRL (RW): bit0 EN, bit1 AUTOCLR, bit2 IE; other bits read 0.
  - 0x04 COUNT (RW).
  - 0x08 COMPARE (RW).
  - 0x0C STATUS: bit0 MATCH (W1C), bit1 OVF (W1C), bit2 FULL (RO), bit3 EMPTY (RO), bits[7:4] LEVEL (RO).
  - 0x10 TXDATA (WO; reads 0).
  - Offsets 0x14–0x1C read 0; writes to them are ignored.
- Writes take effect only when we & hit. When hit = 0, rd = 0.
- Timer, evaluated each cycle:
  - A software write to COUNT has priority and loads wd.
  - Otherwise, if EN = 1 and COUNT == COMPARE: set MATCH; next COUNT is 0 when AUTOCLR = 1, else COUNT+1.
  - Otherwise, if EN = 1: COUNT+1, wrapping from 32'hFFFF_FFFF to 0.
  - If EN = 0, COUNT holds and no match is detected.
- MATCH/OVF: writing 1 to the bit clears it. A set in the same cycle as the clear wins.
- FIFO:
  - A write to TXDATA pushes wd.
  - Pop occurs when tx_valid & tx_ready.
  - Push while full with no pop in that cycle is dropped and sets OVF.
  - Push while full with a pop in that cycle is accepted; LEVEL is unchanged.
  - Push while empty: the word appears on tx_data the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. LEVEL ranges 0..FIFO_DEPTH.
- tx_data and tx_valid must stay stable while tx_valid & ~tx_ready.

## Timing
- Reset values: CTRL 0, COUNT 0, COMPARE 32'hFFFF_FFFF, MATCH 0, OVF 0, LEVEL 0, tx_valid 0, tx_data 0, irq 0.
- rd and hit: zero-latency combinational paths from a.
- Register writes are visible in rd in the cycle after the store edge.
- MATCH is set on the edge where COUNT == COMPARE is sampled. irq rises in the following cycle.
- Push to tx_valid latency: 1 cycle. Pop is visible as the next head word, or tx_valid low, one cycle after the handshake edge.
- Reset asserted mid-operation discards the FIFO contents and all state immediately; no handshake is completed.

## Structure
- Package mmio_pkg holds:
  - offset constants (OFF_CTRL, OFF_COUNT, OFF_COMPARE, OFF_STATUS, OFF_TXDATA);
  - CTRL and STATUS bit-index constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/full/empty/level, head output, synchronous storage. The rest, including the timer and decode, stays in mmio_responder.

## Test plan
- Reset, then read every offset → CTRL 0, COUNT 0, COMPARE 32'hFFFF_FFFF, STATUS 32'h8; tx_valid 0.
- Write COMPARE=5, CTRL=3 (EN, AUTOCLR), COUNT=0 → COUNT counts 0..5 then 0; MATCH set; irq stays 0 until CTRL=7, then 1; a W1C write of STATUS=1 clears MATCH.
- Write COUNT=32'hFFFF_FFFE with EN=1 and COMPARE=0 → COUNT shows FFFF_FFFF, then 0 with MATCH set; an edge with a simultaneous W1C keeps MATCH=1.
- With tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 → LEVEL 4, FULL 1, OVF 1, tx_data 0x11; then tx_ready=1 yields 0x11..0x44 in order and EMPTY 1.
- FIFO full, then push 0x66 in the same cycle as a pop → accepted; LEVEL stays 4; OVF unchanged.
- Store to a=0x64 data 7 → hit 0, no state change; load from a=0x114 → rd 0, hit 1; assert reset mid-drain → tx_valid 0 immediately and LEVEL 0.
